placement_checker: RTL and testbench

- Read-side companion of the placer: runs after a placement run and reads back the pos_X, pos_Y and grid RAMs plus the edge ROMs (EA/EB).
- Checks that the placement is consistent: every node is placed, in bounds, and its grid cell holds its own id.
- Recomputes the wirelength metrics (Manhattan sum and 1-hop sum) over all edges.
- Reports results through a start/done handshake, read-only; used by the simulation benches as an independent checker.

---
 rtl/placement_checker.sv | 181 ++++++++++++++++++
 tb/tb_placement_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/placement_checker.sv
// Read-only consistency checker for a finished placement: validates every node's
// position against the grid RAM, then recomputes wirelength metrics over all edges.
module placement_checker #(
    parameter int N      = 8,
    parameter int N_NODE = 64,
    parameter int N_EDGE = 71,
    parameter int AW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 rePos,
    output logic [AW-1:0]        addrPos,
    input  logic signed [31:0]   doutPX,
    input  logic signed [31:0]   doutPY,
    output logic                 reGrid,
    output logic [AW-1:0]        addrGrid,
    input  logic signed [31:0]   doutGrid,
    output logic                 reE,
    output logic [AW-1:0]        addrE,
    input  logic [31:0]          doutEA,
    input  logic [31:0]          doutEB,
    output logic signed [31:0]   sum,
    output logic signed [31:0]   sum_1hop,
    output logic [15:0]          unplaced_cnt,
    output logic [15:0]          conflict_cnt,
    output logic [15:0]          skipped_cnt
);

    typedef enum logic [3:0] {
        IDLE, N_RD, N_WAIT, N_CHK, G_WAIT, G_CMP, N_NEXT,
        E_RD, E_WAIT, E_A, EA_WAIT, E_B, EB_WAIT, E_ACC, E_NEXT, FIN
    } state_t;

    localparam logic [31:0] LAST_NODE = 32'(N_NODE - 1);
    localparam logic [31:0] LAST_EDGE = 32'(N_EDGE - 1);

    state_t             state, next_state;
    logic [31:0]        idx;
    logic [31:0]        b;
    logic signed [31:0] xa, ya;

    logic        x_unplaced, out_of_bounds, edge_skip;
    logic [31:0] dx, dy, hop_x, hop_y;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    always_comb begin
        x_unplaced    = (doutPX == -32'sd1);
        out_of_bounds = (doutPX < 0) || (doutPX > N - 1) || (doutPY < 0) || (doutPY > N - 1);
        // In E_ACC the pos read-data still holds endpoint b
        edge_skip     = (xa == -32'sd1) || (doutPX == -32'sd1);
        dx            = (xa >= doutPX) ? 32'(xa - doutPX) : 32'(doutPX - xa);
        dy            = (ya >= doutPY) ? 32'(ya - doutPY) : 32'(doutPY - ya);
        hop_x         = (dx >> 1) + {31'b0, dx[0]};
        hop_y         = (dy >> 1) + {31'b0, dy[0]};
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
                if (N_NODE > 0)      next_state = N_RD;
                else if (N_EDGE > 0) next_state = E_RD;
                else                 next_state = FIN;
            end
            N_RD:    next_state = N_WAIT;
            N_WAIT:  next_state = N_CHK;
            N_CHK:   next_state = (x_unplaced || out_of_bounds) ? N_NEXT : G_WAIT;
            G_WAIT:  next_state = G_CMP;
            G_CMP:   next_state = N_NEXT;
            N_NEXT: begin
                if (idx != LAST_NODE)  next_state = N_RD;
                else if (N_EDGE > 0)   next_state = E_RD;
                else                   next_state = FIN;
            end
            E_RD:    next_state = E_WAIT;
            E_WAIT:  next_state = E_A;
            E_A:     next_state = EA_WAIT;
            EA_WAIT: next_state = E_B;
            E_B:     next_state = EB_WAIT;
            EB_WAIT: next_state = E_ACC;
            E_ACC:   next_state = E_NEXT;
            E_NEXT:  next_state = (idx == LAST_EDGE) ? FIN : E_RD;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            b            <= '0;
            xa           <= '0;
            ya           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            rePos        <= 1'b0;
            addrPos      <= '0;
            reGrid       <= 1'b0;
            addrGrid     <= '0;
            reE          <= 1'b0;
            addrE        <= '0;
            sum          <= '0;
            sum_1hop     <= '0;
            unplaced_cnt <= '0;
            conflict_cnt <= '0;
            skipped_cnt  <= '0;
        end else begin
            state  <= next_state;
            rePos  <= 1'b0;
            reGrid <= 1'b0;
            reE    <= 1'b0;
            done   <= (next_state == FIN);
            case (state)
                IDLE: if (start) begin
                    busy         <= 1'b1;
                    pass         <= 1'b0;
                    idx          <= '0;
                    sum          <= '0;
                    sum_1hop     <= '0;
                    unplaced_cnt <= '0;
                    conflict_cnt <= '0;
                    skipped_cnt  <= '0;
                end
                N_RD: begin
                    rePos   <= 1'b1;
                    addrPos <= AW'(idx);
                end
                N_CHK: begin
                    if (x_unplaced)         unplaced_cnt <= sat_inc(unplaced_cnt);
                    else if (out_of_bounds) conflict_cnt <= sat_inc(conflict_cnt);
                    else begin
                        reGrid   <= 1'b1;
                        addrGrid <= AW'(doutPX * N + doutPY);
                    end
                end
                G_CMP: if (doutGrid != idx) conflict_cnt <= sat_inc(conflict_cnt);
                N_NEXT: idx <= (idx == LAST_NODE) ? '0 : idx + 32'd1;
                E_RD: begin
                    reE   <= 1'b1;
                    addrE <= AW'(idx);
                end
                E_A: begin
                    b       <= doutEB;
                    rePos   <= 1'b1;
                    addrPos <= AW'(doutEA);
                end
                E_B: begin
                    xa      <= doutPX;
                    ya      <= doutPY;
                    rePos   <= 1'b1;
                    addrPos <= AW'(b);
                end
                E_ACC: begin
                    if (edge_skip) skipped_cnt <= sat_inc(skipped_cnt);
                    else begin
                        sum      <= sum + dx + dy - 32'd1;
                        sum_1hop <= sum_1hop + hop_x + hop_y - 32'd1;
                    end
                end
                E_NEXT: idx <= idx + 32'd1;
                default: ;
            endcase
            // Entering FIN straight from IDLE means counters are being cleared this edge
            if (next_state == FIN) begin
                busy <= 1'b0;
                pass <= (state == IDLE) ||
                        ((unplaced_cnt == '0) && (conflict_cnt == '0) && (skipped_cnt == '0));
            end
        end
    end

endmodule

// File: tb/tb_placement_checker.sv
// Directed bench for placement_checker: small behavioural RAM/ROM models, fixed
// placements with hand-computed metrics, bus-protocol monitor and mid-run reset.
module tb_placement_checker;
    localparam int N      = 4;
    localparam int N_NODE = 3;
    localparam int N_EDGE = 2;
    localparam int AW     = 32;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic busy, done, pass;
    logic rePos, reGrid, reE;
    logic [AW-1:0] addrPos, addrGrid, addrE;
    logic signed [31:0] doutPX = '0, doutPY = '0, doutGrid = '0;
    logic [31:0] doutEA = '0, doutEB = '0;
    logic signed [31:0] sum, sum_1hop;
    logic [15:0] unplaced_cnt, conflict_cnt, skipped_cnt;

    logic signed [31:0] px [3];
    logic signed [31:0] py [3];
    logic signed [31:0] grid [16];
    logic [31:0] ea [2];
    logic [31:0] eb [2];

    int checks = 0, failures = 0;
    int grid_total = 0, viol = 0;
    logic prev_strobe = 1'b0;

    placement_checker #(.N(N), .N_NODE(N_NODE), .N_EDGE(N_EDGE), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .rePos(rePos), .addrPos(addrPos), .doutPX(doutPX), .doutPY(doutPY),
        .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
        .reE(reE), .addrE(addrE), .doutEA(doutEA), .doutEB(doutEB),
        .sum(sum), .sum_1hop(sum_1hop),
        .unplaced_cnt(unplaced_cnt), .conflict_cnt(conflict_cnt), .skipped_cnt(skipped_cnt)
    );

    always #5 clk = ~clk;

    // Memories capture on the strobe edge; data then holds until the next strobe
    always @(posedge clk) begin
        if (rePos) begin
            doutPX <= (addrPos < 3) ? px[addrPos[1:0]] : 32'sh0BAD_0BAD;
            doutPY <= (addrPos < 3) ? py[addrPos[1:0]] : 32'sh0BAD_0BAD;
        end
        if (reGrid) doutGrid <= (addrGrid < 16) ? grid[addrGrid[3:0]] : 32'sh0BAD_0BAD;
        if (reE) begin
            doutEA <= (addrE < 2) ? ea[addrE[0]] : 32'h0000_00EE;
            doutEB <= (addrE < 2) ? eb[addrE[0]] : 32'h0000_00EE;
        end
        prev_strobe <= rePos | reGrid | reE;
        if ((rePos | reGrid | reE) && prev_strobe) viol <= viol + 1;
        if (reGrid) grid_total <= grid_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setup_case1();
        for (int k = 0; k < 16; k++) grid[k] = -32'sd1;
        px[0] = 0; py[0] = 0;
        px[1] = 0; py[1] = 3;
        px[2] = 2; py[2] = 3;
        grid[0] = 0; grid[3] = 1; grid[11] = 2;
        ea[0] = 0; eb[0] = 1;
        ea[1] = 1; eb[1] = 2;
    endtask

    // n = negedges from the first busy cycle until done is seen
    task automatic run(input bit spam, output int n, output int grids);
        int base;
        base = grid_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        n = 0;
        while (!done && n < 2000) begin
            start = spam && (n % 3 == 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 64'd0, 64'd1);
        grids = grid_total - base;
    endtask

    task automatic after_done(input string tag);
        check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int n, g;
        #12;
        check("rst_ctl", {58'b0, busy, done, pass, rePos, reGrid, reE}, 64'd0);
        check("rst_addr", {32'b0, addrPos | addrGrid | addrE}, 64'd0);
        check("rst_sums", {sum, sum_1hop}, 64'd0);
        check("rst_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, 64'd0);
        @(negedge clk); reset = 1'b1;

        // Case 1: consistent placement
        setup_case1();
        run(1'b0, n, g);
        check("c1_cycles", 64'(n), 64'd34);
        check("c1_pass", {63'b0, pass}, 64'd1);
        check("c1_sum", 64'(sum), 64'd3);
        check("c1_sum_1hop", 64'(sum_1hop), 64'd1);
        check("c1_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, 64'd0);
        check("c1_grid_reads", 64'(g), 64'd3);
        after_done("c1");
        check("c1_hold_sum", 64'(sum), 64'd3);

        // Case 1 again with start pulses while busy
        run(1'b1, n, g);
        check("c1s_cycles", 64'(n), 64'd34);
        check("c1s_pass", {63'b0, pass}, 64'd1);
        check("c1s_sum", 64'(sum), 64'd3);
        after_done("c1s");

        // Case 2: grid cell of node2 holds 1
        setup_case1();
        grid[11] = 1;
        run(1'b0, n, g);
        check("c2_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, {16'b0, 16'd0, 16'd1, 16'd0});
        check("c2_pass", {63'b0, pass}, 64'd0);
        check("c2_sum", 64'(sum), 64'd3);
        check("c2_grid_reads", 64'(g), 64'd3);
        after_done("c2");

        // Case 3: node1 unplaced, both edges skipped
        setup_case1();
        px[1] = -32'sd1; py[1] = -32'sd1; grid[3] = -32'sd1;
        run(1'b0, n, g);
        check("c3_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, {16'b0, 16'd1, 16'd0, 16'd2});
        check("c3_sum", 64'(sum), 64'd0);
        check("c3_sum_1hop", 64'(sum_1hop), 64'd0);
        check("c3_pass", {63'b0, pass}, 64'd0);
        check("c3_grid_reads", 64'(g), 64'd2);
        check("c3_cycles", 64'(n), 64'd32);
        after_done("c3");

        // Case 4: node2 at (4,3) is out of bounds; edge(1,2) has dx=4 -> sum 2+3
        setup_case1();
        px[2] = 4; py[2] = 3;
        run(1'b0, n, g);
        check("c4_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, {16'b0, 16'd0, 16'd1, 16'd0});
        check("c4_sum", 64'(sum), 64'd5);
        check("c4_sum_1hop", 64'(sum_1hop), 64'd2);
        check("c4_grid_reads", 64'(g), 64'd2);
        check("c4_cycles", 64'(n), 64'd32);
        check("c4_pass", {63'b0, pass}, 64'd0);
        after_done("c4");

        // Case 6: asynchronous reset during the edge phase
        setup_case1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (25) @(negedge clk);
        check("mid_sum_before_rst", 64'(sum), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ctl", {58'b0, busy, done, pass, rePos, reGrid, reE}, 64'd0);
        check("mid_rst_addr", {32'b0, addrPos | addrGrid | addrE}, 64'd0);
        check("mid_rst_sums", {sum, sum_1hop}, 64'd0);
        check("mid_rst_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, 64'd0);
        @(negedge clk); reset = 1'b1;
        run(1'b0, n, g);
        check("rerun_cycles", 64'(n), 64'd34);
        check("rerun_pass", {63'b0, pass}, 64'd1);
        check("rerun_sums", {sum, sum_1hop}, {32'd3, 32'd1});
        check("rerun_cnts", {16'b0, unplaced_cnt, conflict_cnt, skipped_cnt}, 64'd0);
        after_done("rerun");

        check("strobe_spacing", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
